// File: rtl/uart_pattern_scanner_pkg.sv
// Shared definitions for the UART pattern scanner: receive FSM encoding and
// baud divider arithmetic.
// No ports; imported by uart_rx_core and uart_pattern_scanner.
package uart_pattern_scanner_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   // Below this the half-bit start check would degenerate.
   localparam int MIN_DIV = 4;

   // Clocks per bit, rounded to nearest.
   function automatic int calc_div(input longint clk_hz, input longint baud);
      longint d;
      d = (clk_hz + baud / 2) / baud;
      return (d < longint'(MIN_DIV)) ? MIN_DIV : int'(d);
   endfunction

   // Wait from the falling edge to the middle of the start bit.
   function automatic int calc_half_div(input int div);
      return div / 2;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART frame receiver: synchronizes rx, times start/data/parity/stop bits, flags errors.
// Latency: 3-flop input path, then one registered pulse per sampled bit and per frame.
// Backpressure: none; pulses are fire-and-forget and the line cannot be stalled.
// Ports: clk, rst (sync, active-high), rx (async line); bit_strobe/bit_val per data bit;
//        rx_data/rx_valid per good frame; framing_error/parity_error pulses.
module uart_rx_core
   import uart_pattern_scanner_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 25_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic                 bit_strobe,
   output logic                 bit_val,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_error,
   output logic                 parity_error
);

   localparam int DIV     = calc_div(longint'(CLK_FREQ_HZ), longint'(BAUD_RATE));
   localparam int HALF    = calc_half_div(DIV);
   localparam int CW      = $clog2(DIV);
   localparam bit PAR_ON  = (PARITY_EN != 0);
   localparam bit PAR_EXP = (PARITY_ODD != 0);

   logic                 rx_s1, rx_s2, rx_s3;
   rx_state_t            state;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_acc;
   logic                 brk;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1         <= 1'b1;
         rx_s2         <= 1'b1;
         rx_s3         <= 1'b1;
         state         <= ST_IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         par_acc       <= 1'b0;
         brk           <= 1'b0;
         bit_strobe    <= 1'b0;
         bit_val       <= 1'b0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         framing_error <= 1'b0;
         parity_error  <= 1'b0;
      end else begin
         rx_s1         <= rx;
         rx_s2         <= rx_s1;
         rx_s3         <= rx_s2;
         bit_strobe    <= 1'b0;
         rx_valid      <= 1'b0;
         framing_error <= 1'b0;
         parity_error  <= 1'b0;

         case (state)
            ST_IDLE: begin
               cnt <= '0;
               brk <= 1'b0;
               if (rx_s3 && !rx_s2) state <= ST_START;
            end
            ST_START: begin
               if (cnt == CW'(HALF - 1)) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  par_acc <= 1'b0;
                  // Line back high by mid start bit: treat as a glitch.
                  state   <= rx_s2 ? ST_IDLE : ST_DATA;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DATA: begin
               if (cnt == CW'(DIV - 1)) begin
                  cnt        <= '0;
                  // LSB arrives first, so shift in from the top.
                  shreg      <= {rx_s2, shreg[DATA_BITS-1:1]};
                  par_acc    <= par_acc ^ rx_s2;
                  bit_strobe <= 1'b1;
                  bit_val    <= rx_s2;
                  if (bit_idx == 3'(DATA_BITS - 1))
                     state <= PAR_ON ? ST_PARITY : ST_STOP;
                  else
                     bit_idx <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_PARITY: begin
               if (cnt == CW'(DIV - 1)) begin
                  cnt     <= '0;
                  par_acc <= par_acc ^ rx_s2;
                  state   <= ST_STOP;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_STOP: begin
               if (brk) begin
                  // Break: hold here until the line returns to idle.
                  if (rx_s2) state <= ST_IDLE;
               end else if (cnt == CW'(DIV - 1)) begin
                  cnt <= '0;
                  // par_acc now holds data ^ parity bit; it must equal PAR_EXP.
                  parity_error <= PAR_ON && (par_acc != PAR_EXP);
                  if (rx_s2) begin
                     if (!(PAR_ON && (par_acc != PAR_EXP))) begin
                        rx_valid <= 1'b1;
                        rx_data  <= shreg;
                     end
                     state <= ST_IDLE;
                  end else begin
                     framing_error <= 1'b1;
                     brk           <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_pattern_scanner.sv
// UART receiver feeding a sliding bit window matched against programmable pattern slots.
// Latency: match pulses one cycle after the data bit_strobe; match_count one cycle later.
// Backpressure: none; every received bit is scanned, errors flush the window.
// Ports: clk, rst, rx; cfg_we/cfg_idx/cfg_pattern/cfg_en slot writes; cnt_clr;
//        receiver outputs from uart_rx_core; shift_window, match, match_count.
module uart_pattern_scanner
   import uart_pattern_scanner_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 25_000_000,
   parameter int BAUD_RATE   = 115_200,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_EN   = 0,
   parameter int PARITY_ODD  = 0,
   parameter int PAT_LEN     = 4,
   parameter int NUM_PAT     = 2,
   parameter int CNT_W       = 8,
   localparam int IDX_W      = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   input  logic                 cfg_we,
   input  logic [IDX_W-1:0]     cfg_idx,
   input  logic [PAT_LEN-1:0]   cfg_pattern,
   input  logic                 cfg_en,
   input  logic                 cnt_clr,
   output logic                 bit_strobe,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 framing_error,
   output logic                 parity_error,
   output logic [PAT_LEN-1:0]   shift_window,
   output logic [NUM_PAT-1:0]   match,
   output logic [CNT_W-1:0]     match_count
);

   localparam int FILL_W = $clog2(PAT_LEN + 1);

   logic                bit_val;
   logic [PAT_LEN-1:0]  pat_q [NUM_PAT];
   logic [NUM_PAT-1:0]  en_q;
   logic [FILL_W-1:0]   fill_q;
   logic [FILL_W-1:0]   fill_nxt;
   logic [PAT_LEN:0]    win_ext;
   logic [PAT_LEN-1:0]  win_nxt;
   logic [NUM_PAT-1:0]  hit;

   uart_rx_core #(
      .CLK_FREQ_HZ (CLK_FREQ_HZ),
      .BAUD_RATE   (BAUD_RATE),
      .DATA_BITS   (DATA_BITS),
      .PARITY_EN   (PARITY_EN),
      .PARITY_ODD  (PARITY_ODD)
   ) u_rx (
      .clk           (clk),
      .rst           (rst),
      .rx            (rx),
      .bit_strobe    (bit_strobe),
      .bit_val       (bit_val),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .framing_error (framing_error),
      .parity_error  (parity_error)
   );

   // Post-shift view, evaluated in the strobe cycle so match lands one cycle later.
   // The extended vector keeps PAT_LEN = 1 legal.
   always_comb begin
      win_ext  = {shift_window, bit_val};
      win_nxt  = win_ext[PAT_LEN-1:0];
      fill_nxt = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);
      hit      = '0;
      for (int i = 0; i < NUM_PAT; i++)
         hit[i] = (fill_nxt == FILL_W'(PAT_LEN)) && en_q[i] && (win_nxt == pat_q[i]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_window <= '0;
         fill_q       <= '0;
         match        <= '0;
         match_count  <= '0;
         en_q         <= '0;
         for (int i = 0; i < NUM_PAT; i++) pat_q[i] <= '0;
      end else begin
         match <= '0;
         if (framing_error || parity_error) begin
            shift_window <= '0;
            fill_q       <= '0;
         end else if (bit_strobe) begin
            shift_window <= win_nxt;
            fill_q       <= fill_nxt;
            match        <= hit;
         end

         if (cfg_we && (int'(cfg_idx) < NUM_PAT)) begin
            pat_q[cfg_idx] <= cfg_pattern;
            en_q[cfg_idx]  <= cfg_en;
         end

         if (cnt_clr)
            match_count <= '0;
         else if ((|match) && (match_count != {CNT_W{1'b1}}))
            match_count <= match_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_uart_pattern_scanner.sv
module tb_uart_pattern_scanner;

   localparam int DIV = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic       cfg_we = 1'b0;
   logic [0:0] cfg_idx = '0;
   logic [3:0] cfg_pattern = '0;
   logic       cfg_en = 1'b0;
   logic       cnt_clr = 1'b0;

   logic       bit_strobe_a, rx_valid_a, framing_error_a, parity_error_a;
   logic [7:0] rx_data_a;
   logic [3:0] shift_window_a;
   logic [1:0] match_a;
   logic [7:0] match_count_a;

   logic       bit_strobe_b, rx_valid_b, framing_error_b, parity_error_b;
   logic [7:0] rx_data_b;
   logic [3:0] shift_window_b;
   logic [1:0] match_b;
   logic [1:0] match_count_b;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];

   int strobe_cnt_a = 0, last_strobe_cyc_a = 0, m0_cnt_a = 0, m1_cnt_a = 0;
   int m0_strobes_a = 0, m0_gap_a = 0, valid_cnt_a = 0, fe_cnt_a = 0, pe_cnt_a = 0;
   int valid_cnt_b = 0, fe_cnt_b = 0, pe_cnt_b = 0, both_cnt_b = 0, part_cnt_b = 0;

   uart_pattern_scanner #(
      .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
      .PARITY_EN(0), .PARITY_ODD(0), .PAT_LEN(4), .NUM_PAT(2), .CNT_W(8)
   ) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_pattern(cfg_pattern), .cfg_en(cfg_en), .cnt_clr(cnt_clr),
      .bit_strobe(bit_strobe_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a),
      .framing_error(framing_error_a), .parity_error(parity_error_a),
      .shift_window(shift_window_a), .match(match_a), .match_count(match_count_a)
   );

   uart_pattern_scanner #(
      .CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
      .PARITY_EN(1), .PARITY_ODD(0), .PAT_LEN(4), .NUM_PAT(2), .CNT_W(2)
   ) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
      .cfg_pattern(cfg_pattern), .cfg_en(cfg_en), .cnt_clr(cnt_clr),
      .bit_strobe(bit_strobe_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b),
      .framing_error(framing_error_b), .parity_error(parity_error_b),
      .shift_window(shift_window_b), .match(match_b), .match_count(match_count_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Monitor A: event counters plus the rx_data scoreboard.
   always @(negedge clk) begin
      if (match_a[0]) begin
         m0_cnt_a     = m0_cnt_a + 1;
         m0_strobes_a = strobe_cnt_a;
         m0_gap_a     = cyc - last_strobe_cyc_a;
      end
      if (match_a[1]) m1_cnt_a = m1_cnt_a + 1;
      if (bit_strobe_a) begin
         strobe_cnt_a      = strobe_cnt_a + 1;
         last_strobe_cyc_a = cyc;
      end
      if (framing_error_a) fe_cnt_a = fe_cnt_a + 1;
      if (parity_error_a)  pe_cnt_a = pe_cnt_a + 1;
      if (rx_valid_a) begin
         logic [7:0] e;
         valid_cnt_a = valid_cnt_a + 1;
         total = total + 1;
         if (exp_a.size() == 0) begin
            bad = bad + 1;
            $display("FAIL sb_a: unexpected rx_valid data=%02h, none expected", rx_data_a);
         end else begin
            e = exp_a.pop_front();
            if (rx_data_a !== e) begin
               bad = bad + 1;
               $display("FAIL sb_a: rx_data=%02h expected %02h", rx_data_a, e);
            end
         end
      end
   end

   // Monitor B.
   always @(negedge clk) begin
      if (match_b == 2'b11) both_cnt_b = both_cnt_b + 1;
      if (match_b == 2'b01 || match_b == 2'b10) part_cnt_b = part_cnt_b + 1;
      if (framing_error_b) fe_cnt_b = fe_cnt_b + 1;
      if (parity_error_b)  pe_cnt_b = pe_cnt_b + 1;
      if (rx_valid_b) begin
         logic [7:0] e;
         valid_cnt_b = valid_cnt_b + 1;
         total = total + 1;
         if (exp_b.size() == 0) begin
            bad = bad + 1;
            $display("FAIL sb_b: unexpected rx_valid data=%02h, none expected", rx_data_b);
         end else begin
            e = exp_b.pop_front();
            if (rx_data_b !== e) begin
               bad = bad + 1;
               $display("FAIL sb_b: rx_data=%02h expected %02h", rx_data_b, e);
            end
         end
      end
   end

   task automatic hold(input bit sel, input logic v, input int n);
      if (sel) rx_b = v; else rx_a = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                             input bit par_bit, input bit stop_bit, input int idle);
      hold(sel, 1'b0, DIV);
      for (int i = 0; i < 8; i++) hold(sel, d[i], DIV);
      if (use_par) hold(sel, par_bit, DIV);
      hold(sel, stop_bit, DIV);
      hold(sel, 1'b1, idle);
   endtask

   task automatic cfg_write(input logic [0:0] idx, input logic [3:0] pat, input logic en);
      @(negedge clk);
      cfg_we = 1'b1; cfg_idx = idx; cfg_pattern = pat; cfg_en = en;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total = total + 1;
      if (rx_data_a !== 8'h00) begin bad = bad + 1; $display("FAIL reset_rx_data: got %02h want 00", rx_data_a); end
      total = total + 1;
      if ({rx_valid_a, bit_strobe_a, framing_error_a, parity_error_a} !== 4'b0) begin
         bad = bad + 1; $display("FAIL reset_pulses: got %b want 0000",
                                  {rx_valid_a, bit_strobe_a, framing_error_a, parity_error_a});
      end
      total = total + 1;
      if (match_a !== 2'b00 || match_count_a !== 8'd0) begin
         bad = bad + 1; $display("FAIL reset_match: match=%b count=%0d want 0/0", match_a, match_count_a);
      end
      total = total + 1;
      if (shift_window_a !== 4'h0) begin bad = bad + 1; $display("FAIL reset_window: got %h want 0", shift_window_a); end
      total = total + 1;
      if (match_count_b !== 2'd0) begin bad = bad + 1; $display("FAIL reset_count_b: got %0d want 0", match_count_b); end
   endtask

   task automatic test_match();
      int s0, m0, m1, v0;
      cfg_write(1'b0, 4'hE, 1'b1);
      s0 = strobe_cnt_a; m0 = m0_cnt_a; m1 = m1_cnt_a; v0 = valid_cnt_a;
      exp_a.push_back(8'h37);
      send_frame(1'b0, 8'h37, 1'b0, 1'b0, 1'b1, 30);
      total = total + 1;
      if (m0_cnt_a - m0 !== 1) begin bad = bad + 1; $display("FAIL match_once: got %0d pulses want 1", m0_cnt_a - m0); end
      total = total + 1;
      if (m0_strobes_a - s0 !== 4 || m0_gap_a !== 1) begin
         bad = bad + 1; $display("FAIL match_timing: strobes=%0d gap=%0d want 4/1", m0_strobes_a - s0, m0_gap_a);
      end
      total = total + 1;
      if (m1_cnt_a - m1 !== 0) begin bad = bad + 1; $display("FAIL match_disabled_slot: got %0d want 0", m1_cnt_a - m1); end
      total = total + 1;
      if (match_count_a !== 8'd1) begin bad = bad + 1; $display("FAIL match_count: got %0d want 1", match_count_a); end
      total = total + 1;
      if (valid_cnt_a - v0 !== 1) begin bad = bad + 1; $display("FAIL match_valid: got %0d want 1", valid_cnt_a - v0); end
      total = total + 1;
      if (shift_window_a !== 4'hC) begin bad = bad + 1; $display("FAIL match_window: got %h want c", shift_window_a); end
   endtask

   task automatic test_glitch();
      int s0, v0, f0, p0;
      s0 = strobe_cnt_a; v0 = valid_cnt_a; f0 = fe_cnt_a; p0 = pe_cnt_a;
      hold(1'b0, 1'b0, 3);
      hold(1'b0, 1'b1, 40);
      total = total + 1;
      if (strobe_cnt_a - s0 !== 0 || valid_cnt_a - v0 !== 0 || fe_cnt_a - f0 !== 0 || pe_cnt_a - p0 !== 0) begin
         bad = bad + 1;
         $display("FAIL glitch: strobes=%0d valid=%0d fe=%0d pe=%0d want all 0",
                  strobe_cnt_a - s0, valid_cnt_a - v0, fe_cnt_a - f0, pe_cnt_a - p0);
      end
   endtask

   task automatic test_framing();
      int v0, f0, m0;
      // Pattern 0001 would hit on the first fresh bit if the fill count survived the error.
      cfg_write(1'b0, 4'h1, 1'b1);
      v0 = valid_cnt_a; f0 = fe_cnt_a; m0 = m0_cnt_a;
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 30);
      total = total + 1;
      if (fe_cnt_a - f0 !== 1) begin bad = bad + 1; $display("FAIL framing_pulse: got %0d want 1", fe_cnt_a - f0); end
      total = total + 1;
      if (valid_cnt_a - v0 !== 0) begin bad = bad + 1; $display("FAIL framing_valid: got %0d want 0", valid_cnt_a - v0); end
      total = total + 1;
      if (shift_window_a !== 4'h0) begin bad = bad + 1; $display("FAIL framing_window: got %h want 0", shift_window_a); end
      exp_a.push_back(8'h01);
      send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 30);
      total = total + 1;
      if (m0_cnt_a - m0 !== 0) begin bad = bad + 1; $display("FAIL framing_refill: got %0d matches want 0", m0_cnt_a - m0); end
      total = total + 1;
      if (match_count_a !== 8'd1) begin bad = bad + 1; $display("FAIL framing_count: got %0d want 1", match_count_a); end
   endtask

   task automatic test_cnt_clr();
      pulse_clr();
      total = total + 1;
      if (match_count_a !== 8'd0) begin bad = bad + 1; $display("FAIL cnt_clr: got %0d want 0", match_count_a); end
   endtask

   task automatic test_parity();
      int v0, p0, f0;
      v0 = valid_cnt_b; p0 = pe_cnt_b; f0 = fe_cnt_b;
      send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 30);
      total = total + 1;
      if (pe_cnt_b - p0 !== 1) begin bad = bad + 1; $display("FAIL parity_pulse: got %0d want 1", pe_cnt_b - p0); end
      total = total + 1;
      if (valid_cnt_b - v0 !== 0 || fe_cnt_b - f0 !== 0) begin
         bad = bad + 1; $display("FAIL parity_side: valid=%0d fe=%0d want 0/0", valid_cnt_b - v0, fe_cnt_b - f0);
      end
      exp_b.push_back(8'h01);
      send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 30);
      total = total + 1;
      if (valid_cnt_b - v0 !== 1 || pe_cnt_b - p0 !== 1) begin
         bad = bad + 1; $display("FAIL parity_good: valid=%0d pe=%0d want 1/1", valid_cnt_b - v0, pe_cnt_b - p0);
      end
   endtask

   task automatic test_back_to_back();
      int b0, p0;
      int want;
      cfg_write(1'b0, 4'hE, 1'b1);
      cfg_write(1'b1, 4'hE, 1'b1);
      pulse_clr();
      b0 = both_cnt_b; p0 = part_cnt_b;
      for (int i = 0; i < 4; i++) begin
         exp_b.push_back(8'h37);
         // 0x37 carries five ones, so even parity sends 1.
         send_frame(1'b1, 8'h37, 1'b1, 1'b1, 1'b1, 0);
         want = (i + 1 > 3) ? 3 : i + 1;
         total = total + 1;
         if (int'(match_count_b) !== want) begin
            bad = bad + 1; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, match_count_b, want);
         end
      end
      hold(1'b1, 1'b1, 30);
      total = total + 1;
      if (both_cnt_b - b0 !== 4 || part_cnt_b - p0 !== 0) begin
         bad = bad + 1; $display("FAIL b2b_match: both=%0d partial=%0d want 4/0", both_cnt_b - b0, part_cnt_b - p0);
      end
      pulse_clr();
      total = total + 1;
      if (match_count_b !== 2'd0) begin bad = bad + 1; $display("FAIL b2b_clr: got %0d want 0", match_count_b); end
   endtask

   task automatic test_reset_midframe();
      int v0, f0, p0, m0;
      v0 = valid_cnt_a; f0 = fe_cnt_a; p0 = pe_cnt_a; m0 = m0_cnt_a;
      hold(1'b0, 1'b0, DIV);
      hold(1'b0, 1'b1, DIV);
      hold(1'b0, 1'b1, DIV);
      hold(1'b0, 1'b1, DIV / 2);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hold(1'b0, 1'b1, 20);
      total = total + 1;
      if (rx_data_a !== 8'h00 || valid_cnt_a - v0 !== 0) begin
         bad = bad + 1; $display("FAIL midrst_abort: rx_data=%02h valid=%0d want 00/0", rx_data_a, valid_cnt_a - v0);
      end
      exp_a.push_back(8'h37);
      send_frame(1'b0, 8'h37, 1'b0, 1'b0, 1'b1, 30);
      total = total + 1;
      if (fe_cnt_a - f0 !== 0 || pe_cnt_a - p0 !== 0) begin
         bad = bad + 1; $display("FAIL midrst_errors: fe=%0d pe=%0d want 0/0", fe_cnt_a - f0, pe_cnt_a - p0);
      end
      total = total + 1;
      if (valid_cnt_a - v0 !== 1 || rx_data_a !== 8'h37) begin
         bad = bad + 1; $display("FAIL midrst_rx: valid=%0d data=%02h want 1/37", valid_cnt_a - v0, rx_data_a);
      end
      // Reset disabled every slot, so the same byte must not match now.
      total = total + 1;
      if (m0_cnt_a - m0 !== 0 || match_count_a !== 8'd0) begin
         bad = bad + 1; $display("FAIL midrst_slots: matches=%0d count=%0d want 0/0", m0_cnt_a - m0, match_count_a);
      end
   endtask

   initial begin
      test_reset();
      test_match();
      test_glitch();
      test_framing();
      test_cnt_clr();
      test_parity();
      test_back_to_back();
      test_reset_midframe();
      total = total + 1;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         bad = bad + 1; $display("FAIL sb_drain: pending a=%0d b=%0d want 0/0", exp_a.size(), exp_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_pattern_scanner.md
UART_PATTERN_SCANNER -- requirements
Module: uart_pattern_scanner

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- CLK_FREQ_HZ, 25_000_000, clock frequency.
- BAUD_RATE, 115_200, line rate. DIV = round(CLK_FREQ_HZ/BAUD_RATE), minimum 4.
- DATA_BITS, 8, data bits per frame, 5..8.
- PARITY_EN, 0, enables a parity bit.
- PARITY_ODD, 0, selects odd parity; 0 selects even.
- PAT_LEN, 4, pattern length in bits, 1..16.
- NUM_PAT, 2, number of pattern slots, 1..4.
- CNT_W, 8, match counter width.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock.
- rst, in, 1, synchronous reset, active-high.
- rx, in, 1, asynchronous serial input; idle level is 1.
- cfg_we, in, 1, pattern-slot write strobe.
- cfg_idx, in, clog2(NUM_PAT) (minimum 1), slot index.
- cfg_pattern, in, PAT_LEN, pattern value.
- cfg_en, in, 1, slot enable written with the pattern.
- cnt_clr, in, 1, clears match_count.
- bit_strobe, out, 1, one-cycle pulse per accepted data bit.
- rx_data, out, DATA_BITS, last good frame, LSB = first bit received.
- rx_valid, out, 1, one-cycle pulse per good frame.
- framing_error, out, 1, one-cycle pulse.
- parity_error, out, 1, one-cycle pulse.
- shift_window, out, PAT_LEN, bit-stream window.
- match, out, NUM_PAT, one-cycle pulse per slot.
- match_count, out, CNT_W, saturating count of match events.

Function
REQ-003 rx SHALL pass through a 2-flop synchronizer before any use; every timing below is stated relative to the synchronized signal.
REQ-004 The receive FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
- IDLE -> START on a synchronized falling edge.
- START waits DIV/2 cycles. If rx is still 0, go to DATA; otherwise return to IDLE (glitch rejected, no outputs).
REQ-005 DATA SHALL sample rx every DIV cycles, DATA_BITS times, and pulse bit_strobe in each sample cycle.
REQ-006 After DATA, the FSM SHALL go to PARITY if PARITY_EN, otherwise to STOP; PARITY samples one bit after DIV cycles.
REQ-007 STOP SHALL sample after DIV cycles.
- Stop bit = 1 and parity OK: pulse rx_valid, update rx_data, go to IDLE.
- Stop bit = 0: pulse framing_error, then wait in STOP until rx = 1 before IDLE (break handling).
- Parity mismatch: pulse parity_error at the stop sample; rx_valid stays 0.
REQ-008 On each bit_strobe: shift_window <= {shift_window[PAT_LEN-2:0], bit}, and a fill counter increments, saturating at PAT_LEN.
- The window spans frame boundaries; only data bits enter it.
REQ-009 A framing or parity error SHALL clear the fill counter and shift_window in the same cycle as the error pulse.
REQ-010 match[i] SHALL pulse in the cycle after a bit_strobe when all of these hold:
- the fill counter is PAT_LEN after the shift;
- the slot is enabled;
- the post-shift window equals pattern[i].
Overlapping matches are required.
REQ-011 match_count SHALL increment by exactly 1 in each cycle where any match bit is set, and saturate at 2^CNT_W-1.
- cnt_clr has priority over increment: count = 0 that cycle.
REQ-012 A cfg_we write SHALL take effect on the next clock; a match evaluated in the write cycle uses the old slot contents.
REQ-013 The block SHALL ignore cfg_idx >= NUM_PAT.

Reset
REQ-014 While rst = 1 at a clock edge:
- FSM -> IDLE; synchronizer -> 1; all counters, windows and pulse outputs -> 0;
- rx_data -> 0; pattern slots -> 0 and disabled.
REQ-015 Reset asserted mid-frame SHALL abort the frame with no error pulse; the first falling edge after release starts a new frame.

Structure
REQ-016 A shared package SHALL hold the FSM state encoding and the DIV/half-DIV computation function.
REQ-017 Frame timing and sampling (REQ-003..007) SHALL be one sub-module, uart_rx_core; window, slots, matching and counter live in the top.

Verification (sim parameters: CLK_FREQ_HZ = 1_000_000, BAUD_RATE = 100_000, so DIV = 10; PAT_LEN = 4)
REQ-018 Pattern 0 = 4'hE, enabled; send 0x37 -> match[0] pulses once, 1 cycle after the 4th bit_strobe; match_count = 1; rx_data = 0x37; rx_valid pulses once.
REQ-019 rx low for 3 cycles, then high -> no bit_strobe, no rx_valid, no error pulse.
REQ-020 Send 0x55 with stop bit 0 -> framing_error pulses once, no rx_valid, shift_window = 0; the next match requires 4 fresh bits.
REQ-021 PARITY_EN = 1, even parity; send 0x01 with parity bit 0 -> parity_error pulses once, no rx_valid.
REQ-022 Both slots = 4'hE, CNT_W = 2; send 0x37 four times -> match = 2'b11 pulses together each time; match_count saturates at 3; cnt_clr -> 0.
REQ-023 rst pulsed during the 3rd data bit, then 0x37 sent -> no error pulses; 0x37 is received correctly.
